dmem_responder: RTL and testbench

- Memory-side end of the core's data-memory transaction interface.
- Accepts a request (memory_transaction, mem_write, byte address, 128-bit write line, 16 byte enablers) from the RV32I core.
- Sequences one access on a synchronous single-port 128-bit RAM with configurable latency, then returns the read line and a one-cycle data_ready.
- Replaces the fixed-timing transaction FSM so the core works against RAMs of any latency.

---
 rtl/dmem_if_pkg.sv | 29 ++
 rtl/dmem_lat_counter.sv | 39 +++
 rtl/dmem_responder.sv | 175 +++++++++++++++++
 tb/tb_dmem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_if_pkg.sv
// Shared types and constants for the data-memory responder: line geometry,
// sequencer states and the latched request record.
package dmem_if_pkg;

  localparam int LINE_W     = 128;
  localparam int LINE_BYTES = 16;
  localparam int OFFSET_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_FAULT = 3'd4
  } dmem_state_t;

  typedef struct packed {
    logic                  write;
    logic [31:0]           addr;
    logic [LINE_W-1:0]     data;
    logic [LINE_BYTES-1:0] be;
  } dmem_req_t;

  // Any set bit above the decoded window makes the request unserviceable.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned addr_w);
    return ((addr >> addr_w) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_lat_counter.sv
// Loadable down-counter; done_o flags the final cycle of a wait (count == 1).
module dmem_lat_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             async_reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: latches one core request, runs it against a
// single-port RAM of configurable latency and returns a one-cycle data_ready.
module dmem_responder
  import dmem_if_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 0
) (
  input  logic                       clock,
  input  logic                       async_reset,
  input  logic                       memory_transaction,
  input  logic                       mem_write,
  input  logic [31:0]                address,
  input  logic [LINE_W-1:0]          write_data,
  input  logic [LINE_BYTES-1:0]      byte_enablers,
  output logic [LINE_W-1:0]          read_data,
  output logic                       data_ready,
  output logic                       busy,
  output logic                       addr_fault,
  output logic [ADDR_W-OFFSET_W-1:0] ram_address,
  output logic [LINE_W-1:0]          ram_data_in,
  output logic [LINE_BYTES-1:0]      ram_byte_en,
  output logic                       ram_write_enable,
  output logic                       ram_read_enable,
  input  logic [LINE_W-1:0]          ram_data_out
);

  localparam int LINE_AW = ADDR_W - OFFSET_W;
  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] WR_LAT_C = CNT_W'(WR_LAT);
  localparam logic WR_NO_WAIT = (WR_LAT == 0) ? 1'b1 : 1'b0;

  dmem_state_t state_q, state_d;
  dmem_req_t   req_q, req_d;
  logic        cnt_done_s;

  logic [LINE_W-1:0]     read_data_q, read_data_d;
  logic                  data_ready_q, data_ready_d;
  logic                  busy_q, busy_d;
  logic                  addr_fault_q, addr_fault_d;
  logic [LINE_AW-1:0]    ram_address_q, ram_address_d;
  logic [LINE_W-1:0]     ram_data_in_q, ram_data_in_d;
  logic [LINE_BYTES-1:0] ram_byte_en_q, ram_byte_en_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_re_q, ram_re_d;

  dmem_lat_counter #(.CNT_W(CNT_W)) u_lat (
    .clock      (clock),
    .async_reset(async_reset),
    .load_i     (state_q == ST_ISSUE),
    .load_val_i (req_q.write ? WR_LAT_C : RD_LAT_C),
    .dec_i      (state_q == ST_WAIT),
    .done_o     (cnt_done_s)
  );

  // State and latched-request registers.
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // Next-state logic; the request is only sampled while idle.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (memory_transaction) begin
          req_d.write = mem_write;
          req_d.addr  = address;
          req_d.data  = write_data;
          req_d.be    = byte_enablers;
          if (addr_out_of_range(address, ADDR_W)) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (req_q.write && WR_NO_WAIT) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_done_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output next values, decoded from the state being entered so that every
  // output is a flop aligned with its state.
  always_comb begin
    data_ready_d  = (state_d == ST_RESP) || (state_d == ST_FAULT);
    addr_fault_d  = (state_d == ST_FAULT);
    busy_d        = (state_d != ST_IDLE);
    ram_re_d      = (state_d == ST_ISSUE) && !req_d.write;
    ram_we_d      = (state_d == ST_ISSUE) && req_d.write && (req_d.be != '0);
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    ram_byte_en_d = ram_byte_en_q;
    read_data_d   = read_data_q;
    if (state_d == ST_ISSUE) begin
      ram_address_d = LINE_AW'(req_d.addr >> OFFSET_W);
      ram_data_in_d = req_d.data;
      ram_byte_en_d = req_d.be;
    end else begin
      ram_address_d = ram_address_q;
      ram_data_in_d = ram_data_in_q;
      ram_byte_en_d = ram_byte_en_q;
    end
    if (state_d == ST_FAULT) begin
      read_data_d = '0;
    end else if ((state_q == ST_WAIT) && cnt_done_s && !req_q.write) begin
      read_data_d = ram_data_out;
    end else begin
      read_data_d = read_data_q;
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      read_data_q   <= '0;
      data_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      addr_fault_q  <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      ram_byte_en_q <= '0;
      ram_we_q      <= 1'b0;
      ram_re_q      <= 1'b0;
    end else begin
      read_data_q   <= read_data_d;
      data_ready_q  <= data_ready_d;
      busy_q        <= busy_d;
      addr_fault_q  <= addr_fault_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      ram_byte_en_q <= ram_byte_en_d;
      ram_we_q      <= ram_we_d;
      ram_re_q      <= ram_re_d;
    end
  end

  assign read_data        = read_data_q;
  assign data_ready       = data_ready_q;
  assign busy             = busy_q;
  assign addr_fault       = addr_fault_q;
  assign ram_address      = ram_address_q;
  assign ram_data_in      = ram_data_in_q;
  assign ram_byte_en      = ram_byte_en_q;
  assign ram_write_enable = ram_we_q;
  assign ram_read_enable  = ram_re_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a behavioural RAM of read latency RD_LAT.
module tb_dmem_responder;

  localparam int ADDR_W  = 20;
  localparam int RD_LAT  = 2;
  localparam int WR_LAT  = 1;
  localparam int LINE_AW = ADDR_W - 4;
  localparam logic [127:0] POISON = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  localparam logic [127:0] L10  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] L20  = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] W20  = 128'hFFEEDDCCBBAA998877665544AABBCCDD;
  localparam logic [127:0] LTOP = 128'hC0FFEE0000000000123456789ABCDEF0;
  localparam logic [127:0] L0   = 128'h5A5A5A5AA5A5A5A50F0F0F0FF0F0F0F0;
  localparam logic [127:0] W0   = 128'hEE5A5A5AA5A5A5A50F0F0F0FF0F0F0F0;

  logic               clock = 1'b0;
  logic               async_reset = 1'b0;
  logic               memory_transaction = 1'b0;
  logic               mem_write = 1'b0;
  logic [31:0]        address = 32'd0;
  logic [127:0]       write_data = 128'd0;
  logic [15:0]        byte_enablers = 16'd0;
  logic [127:0]       read_data;
  logic               data_ready, busy, addr_fault;
  logic [LINE_AW-1:0] ram_address;
  logic [127:0]       ram_data_in;
  logic [15:0]        ram_byte_en;
  logic               ram_write_enable, ram_read_enable;
  logic [127:0]       ram_data_out;

  int n_chk  = 0;
  int n_fail = 0;

  dmem_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clock             (clock),
    .async_reset       (async_reset),
    .memory_transaction(memory_transaction),
    .mem_write         (mem_write),
    .address           (address),
    .write_data        (write_data),
    .byte_enablers     (byte_enablers),
    .read_data         (read_data),
    .data_ready        (data_ready),
    .busy              (busy),
    .addr_fault        (addr_fault),
    .ram_address       (ram_address),
    .ram_data_in       (ram_data_in),
    .ram_byte_en       (ram_byte_en),
    .ram_write_enable  (ram_write_enable),
    .ram_read_enable   (ram_read_enable),
    .ram_data_out      (ram_data_out)
  );

  always #5 clock = ~clock;

  // RAM model: byte-masked write, read data valid for exactly one cycle RD_LAT edges after the strobe.
  logic [127:0]      mem [0:65535];
  logic [127:0]      rd_pipe [RD_LAT];
  logic [RD_LAT-1:0] rd_vld = '0;

  always @(posedge clock) begin
    rd_pipe[0] <= mem[ram_address];
    rd_vld[0]  <= ram_read_enable;
    for (int s = 1; s < RD_LAT; s++) begin
      rd_pipe[s] <= rd_pipe[s-1];
      rd_vld[s]  <= rd_vld[s-1];
    end
    if (ram_write_enable) begin
      for (int b = 0; b < 16; b++) begin
        if (ram_byte_en[b]) mem[ram_address][b*8 +: 8] = ram_data_in[b*8 +: 8];
      end
    end
  end

  assign ram_data_out = rd_vld[RD_LAT-1] ? rd_pipe[RD_LAT-1] : POISON;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  be;
    logic [127:0] exp_rd;
    logic         exp_fault;
    int           exp_lat;
    int           exp_rd_str;
    int           exp_wr_str;
    logic [15:0]  exp_line;
  } vec_t;

  // One request: k counts sample points #1 after each edge, k=1 right after the sampling edge.
  task automatic run_req(input string nm, input vec_t v);
    int k, rd, wr;
    logic seen;
    logic [15:0] sa, sb;
    @(negedge clock);
    mem_write = v.wr; address = v.addr; write_data = v.data; byte_enablers = v.be;
    memory_transaction = 1'b1;
    k = 0; rd = 0; wr = 0; seen = 1'b0; sa = 16'd0; sb = 16'd0;
    while (!seen && k < 20) begin
      @(posedge clock); #1;
      k++;
      if (ram_read_enable) begin rd++; sa = ram_address; end
      if (ram_write_enable) begin wr++; sa = ram_address; sb = ram_byte_en; end
      if (data_ready) seen = 1'b1;
      address = 32'hFFFF_FFFF; write_data = ~v.data; mem_write = ~v.wr; byte_enablers = ~v.be;
    end
    memory_transaction = 1'b0;
    chk({nm, " responded"}, 128'(seen), 128'(1'b1));
    chk({nm, " latency"}, 128'(k), 128'(v.exp_lat));
    chk({nm, " read_data"}, read_data, v.exp_rd);
    chk({nm, " addr_fault"}, 128'(addr_fault), 128'(v.exp_fault));
    chk({nm, " rd strobes"}, 128'(rd), 128'(v.exp_rd_str));
    chk({nm, " wr strobes"}, 128'(wr), 128'(v.exp_wr_str));
    if ((v.exp_rd_str + v.exp_wr_str) > 0) chk({nm, " ram_address"}, 128'(sa), 128'(v.exp_line));
    if (v.exp_wr_str > 0) chk({nm, " ram_byte_en"}, 128'(sb), 128'(v.be));
    @(posedge clock); #1;
    chk({nm, " idle after"}, 128'({data_ready, busy, addr_fault, ram_read_enable, ram_write_enable}), 128'(5'b0));
  endtask

  vec_t vecs [11];
  int pulses, c1, c2, idle_between, busy_viol, late_pulses;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 128'd0;
    mem[16'h0010] = L10;
    mem[16'h0020] = L20;
    mem[16'hFFFF] = LTOP;
    mem[16'h0000] = L0;

    //           wr    addr           data                                       be        exp_rd flt lat rd wr line
    vecs[0]  = '{1'b0, 32'h0000_0100, 128'd0,                                    16'h0000, L10,   1'b0, 4, 1, 0, 16'h0010};
    vecs[1]  = '{1'b1, 32'h0000_0200, 128'h111111112222222233333333AABBCCDD,    16'h000F, L10,   1'b0, 3, 0, 1, 16'h0020};
    vecs[2]  = '{1'b0, 32'h0000_0200, 128'd0,                                    16'h0000, W20,   1'b0, 4, 1, 0, 16'h0020};
    vecs[3]  = '{1'b1, 32'h0000_0204, {4{32'h5555_5555}},                        16'h0000, W20,   1'b0, 3, 0, 0, 16'h0020};
    vecs[4]  = '{1'b0, 32'h0000_0208, 128'd0,                                    16'h0000, W20,   1'b0, 4, 1, 0, 16'h0020};
    vecs[5]  = '{1'b0, 32'h0010_0000, 128'd0,                                    16'h0000, 128'd0, 1'b1, 1, 0, 0, 16'h0000};
    vecs[6]  = '{1'b0, 32'h000F_FFF0, 128'd0,                                    16'h0000, LTOP,  1'b0, 4, 1, 0, 16'hFFFF};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF0, {4{32'h7777_7777}},                        16'hFFFF, 128'd0, 1'b1, 1, 0, 0, 16'h0000};
    vecs[8]  = '{1'b0, 32'h0000_000C, 128'd0,                                    16'h0000, L0,    1'b0, 4, 1, 0, 16'h0000};
    vecs[9]  = '{1'b1, 32'h0000_0000, 128'hEE000000000000000000000000000099,    16'h8000, L0,    1'b0, 3, 0, 1, 16'h0000};
    vecs[10] = '{1'b0, 32'h0000_0000, 128'd0,                                    16'h0000, W0,    1'b0, 4, 1, 0, 16'h0000};

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    chk("reset read_data", read_data, 128'd0);
    chk("reset ctrl", 128'({data_ready, busy, addr_fault, ram_read_enable, ram_write_enable, ram_byte_en, ram_address}),
        128'(0));
    chk("reset ram_data_in", ram_data_in, 128'd0);
    @(negedge clock);
    async_reset = 1'b1;

    for (int i = 0; i < 11; i++) run_req($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back: memory_transaction stays high across two requests.
    @(negedge clock);
    mem_write = 1'b0; address = 32'h0000_0100; memory_transaction = 1'b1;
    pulses = 0; c1 = 0; c2 = 0; idle_between = 0; busy_viol = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clock); #1;
      if (data_ready && !busy) busy_viol++;
      if (data_ready) begin
        pulses++;
        if (pulses == 1) begin
          c1 = c;
          chk("b2b first read_data", read_data, L10);
          address = 32'h0000_0200;
        end else begin
          c2 = c;
          memory_transaction = 1'b0;
        end
      end else if (pulses == 1 && !busy) begin
        idle_between = 1;
      end
    end
    chk("b2b pulses", 128'(pulses), 128'(2));
    chk("b2b spacing", 128'(c2 - c1), 128'(5));
    chk("b2b idle gap", 128'(idle_between), 128'(1));
    chk("b2b busy in resp", 128'(busy_viol), 128'(0));
    chk("b2b second read_data", read_data, W20);

    // Reset asserted between edges while the read is in WAIT.
    @(negedge clock);
    mem_write = 1'b0; address = 32'h0000_0100; memory_transaction = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #3;
    chk("pre-reset busy", 128'(busy), 128'(1'b1));
    async_reset = 1'b0;
    #1;
    chk("midreset read_data", read_data, 128'd0);
    chk("midreset ctrl", 128'({data_ready, busy, addr_fault, ram_read_enable, ram_write_enable, ram_byte_en, ram_address}),
        128'(0));
    chk("midreset ram_data_in", ram_data_in, 128'd0);
    memory_transaction = 1'b0;
    @(negedge clock);
    async_reset = 1'b1;
    late_pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      if (data_ready || busy) late_pulses++;
    end
    chk("no response after reset", 128'(late_pulses), 128'(0));
    run_req("post-reset read", vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
